// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared defaults, fill-width helper and fill-state naming for the
// serial pattern detector.
package seqdet_pkg;

  localparam int             SEQDET_LEN     = 4;
  localparam logic [3:0]     SEQDET_PATTERN = 4'b1101;
  localparam int             SEQDET_CNT_W   = 8;

  // Coarse view of the fill counter: 0, 1..LEN-1, LEN.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  // fill must hold every value 0..len inclusive.
  function automatic int fill_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seqdet_if.sv
// seqdet_if: serial-in / match-out bundle between a bit-serial source and the detector.
// Build with SEQDET_CARE_MASK_EN to add the per-bit care_mask signal.
`ifdef SEQDET_CARE_MASK_EN
interface seqdet_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             w;
  logic [LEN-1:0]   care_mask;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             hist_full;

  modport master (output en, w, care_mask, input z, match_cnt, hist_full);
  modport slave  (input en, w, care_mask, output z, match_cnt, hist_full);
endinterface
`else
interface seqdet_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             w;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             hist_full;

  modport master (output en, w, input z, match_cnt, hist_full);
  modport slave  (input en, w, output z, match_cnt, hist_full);
endinterface
`endif

// File: rtl/seqdet_history.sv
// seqdet_history: shift history plus fill counter; fill is the EMPTY/FILLING/FULL state.
module seqdet_history
  import seqdet_pkg::*;
#(
  parameter int LEN = SEQDET_LEN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_en,
  input  logic           i_w,
  input  logic           i_clear_fill,
  output logic [LEN-1:0] o_nh,
  output logic           o_primed,
  output logic           o_hist_full
);
  localparam int FW = fill_width(LEN);

  // The oldest history bit is shifted out by every new sample and never read,
  // so only the newest LEN-1 bits are stored.
  logic [LEN-2:0] r_hist;
  logic [FW-1:0]  r_fill;
  logic [FW-1:0]  w_fill_next;

  assign o_nh        = {r_hist, i_w};
  assign o_primed    = (r_fill >= FW'(LEN - 1));
  assign o_hist_full = (r_fill == FW'(LEN));

  always_comb begin
    w_fill_next = r_fill;
    if (i_en) begin
      if (i_clear_fill) begin
        w_fill_next = '0;
      end else if (r_fill != FW'(LEN)) begin
        w_fill_next = r_fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_fill <= w_fill_next;
      if (i_en) begin
        r_hist <= o_nh[LEN-2:0];
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: LEN-bit serial pattern detector, overlap select, saturating match count.
// Build with SEQDET_CARE_MASK_EN to compare only the bits set in bus.care_mask.
module seq_pattern_detector
  import seqdet_pkg::*;
#(
  parameter int             LEN     = SEQDET_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(SEQDET_PATTERN),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = SEQDET_CNT_W
) (
  input logic     clk,
  input logic     reset,
  seqdet_if.slave bus
);
  logic [LEN-1:0]   w_nh;
  logic             w_primed;
  logic             w_cmp;
  logic             w_match;
  logic             w_clear_fill;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;

  if (LEN < 2 || LEN > 32) begin : g_len_check
    $error("seq_pattern_detector: LEN must be in 2..32");
  end

  seqdet_history #(
    .LEN(LEN)
  ) u_hist (
    .clk          (clk),
    .reset        (reset),
    .i_en         (bus.en),
    .i_w          (bus.w),
    .i_clear_fill (w_clear_fill),
    .o_nh         (w_nh),
    .o_primed     (w_primed),
    .o_hist_full  (bus.hist_full)
  );

`ifdef SEQDET_CARE_MASK_EN
  assign w_cmp = (((w_nh ^ PATTERN) & bus.care_mask) == '0);
`else
  assign w_cmp = (w_nh == PATTERN);
`endif

  // Leading reset zeros can never match: a full window of real samples is required.
  assign w_match      = bus.en && w_primed && w_cmp;
  assign w_clear_fill = w_match && !OVERLAP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_z   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_z <= w_match;
      if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.z         = r_z;
  assign bus.match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: three detector variants on one shared stream, checked by a
// queue-based scoreboard against a bit-queue reference model.
module tb_seq_pattern_detector;
  import seqdet_pkg::*;

  localparam int L = 4;

  logic clk;
  logic rst_s;
  logic en_s;
  logic w_s;

  int n_chk  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  typedef struct packed {
    logic [2:0] z;
    logic [2:0] hf;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t sb[$];
  exp_t mx;

  // Reference state: bits accepted since the last reset / non-overlap match, oldest first.
  bit             hq[3][$];
  int             cnt[3];
  logic [L-1:0]   pat[3]  = '{4'b1101, 4'b1101, 4'b1111};
  bit             ovl[3]  = '{1'b1, 1'b0, 1'b1};
  int             cmax[3] = '{255, 255, 3};

`ifdef SEQDET_CARE_MASK_EN
  seqdet_if #(.LEN(L), .CNT_W(8)) ifa ();
  seqdet_if #(.LEN(L), .CNT_W(8)) ifb ();
  seqdet_if #(.LEN(L), .CNT_W(2)) ifc ();
  assign ifa.care_mask = '1;
  assign ifb.care_mask = '1;
  assign ifc.care_mask = '1;
`else
  seqdet_if #(.CNT_W(8)) ifa ();
  seqdet_if #(.CNT_W(8)) ifb ();
  seqdet_if #(.CNT_W(2)) ifc ();
`endif

  assign ifa.en = en_s;
  assign ifa.w  = w_s;
  assign ifb.en = en_s;
  assign ifb.w  = w_s;
  assign ifc.en = en_s;
  assign ifc.w  = w_s;

  seq_pattern_detector #(.LEN(L), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .reset(rst_s), .bus(ifa));
  seq_pattern_detector #(.LEN(L), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(rst_s), .bus(ifb));
  seq_pattern_detector #(.LEN(L), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .reset(rst_s), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %0d, expected %0d", nm, n_txn, act, exp);
    end
  endtask

  task automatic model_step(input int d, input bit r, input bit e, input bit b,
                            output bit z, output bit hf, output int c);
    fill_state_e st;
    bit m;
    z = 1'b0;
    if (r) begin
      hq[d].delete();
      cnt[d] = 0;
    end else if (e) begin
      hq[d].push_back(b);
      if (hq[d].size() > L) void'(hq[d].pop_front());
      m = (hq[d].size() == L);
      if (m) begin
        for (int i = 0; i < L; i++) begin
          if (hq[d][i] != pat[d][L-1-i]) m = 1'b0;
        end
      end
      if (m) begin
        z = 1'b1;
        if (cnt[d] < cmax[d]) cnt[d]++;
        if (!ovl[d]) hq[d].delete();
      end
    end
    if (hq[d].size() == 0)      st = EMPTY;
    else if (hq[d].size() == L) st = FULL;
    else                        st = FILLING;
    hf = (st == FULL);
    c  = cnt[d];
  endtask

  // Drive one edge's inputs, queue the expected post-edge outputs, advance past the edge.
  task automatic step(input bit r, input bit e, input bit b);
    exp_t x;
    bit   zz;
    bit   hh;
    int   cc;
    rst_s = r;
    en_s  = e;
    w_s   = b;
    x = '0;
    for (int d = 0; d < 3; d++) begin
      model_step(d, r, e, b, zz, hh, cc);
      x.z[d]  = zz;
      x.hf[d] = hh;
      case (d)
        0:       x.c0 = cc[7:0];
        1:       x.c1 = cc[7:0];
        default: x.c2 = cc[7:0];
      endcase
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a result every cycle; compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mx = sb.pop_front();
        n_txn++;
        $display("txn %0d: rst=%b en=%b w=%b z=%b%b%b cnt=%0d/%0d/%0d hist_full=%b%b%b",
                 n_txn, rst_s, en_s, w_s, ifa.z, ifb.z, ifc.z,
                 ifa.match_cnt, ifb.match_cnt, ifc.match_cnt,
                 ifa.hist_full, ifb.hist_full, ifc.hist_full);
        check("z_ovl",       32'(ifa.z),         32'(mx.z[0]));
        check("z_novl",      32'(ifb.z),         32'(mx.z[1]));
        check("z_sat",       32'(ifc.z),         32'(mx.z[2]));
        check("cnt_ovl",     32'(ifa.match_cnt), 32'(mx.c0));
        check("cnt_novl",    32'(ifb.match_cnt), 32'(mx.c1));
        check("cnt_sat",     32'(ifc.match_cnt), 32'(mx.c2));
        check("full_ovl",    32'(ifa.hist_full), 32'(mx.hf[0]));
        check("full_novl",   32'(ifb.hist_full), 32'(mx.hf[1]));
        check("full_sat",    32'(ifc.hist_full), 32'(mx.hf[2]));
      end
    end
  end

  bit s_main[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit s_pat[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    bit r;
    bit e;
    bit b;

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // Overlapping stream 1101101 then idle edges.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, s_main[i]);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Enable toggling with w=0 on disabled edges.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, s_pat[i]);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Mid-stream reset discards partial history.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, s_pat[i]);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, s_pat[i]);

    // Long run of ones drives the narrow counter into saturation.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic with sparse resets and ~75% enable.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 9) < 6);
      step(r, e, b);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
